// File: rtl/mul16_seq_if.sv
// Operand/result bundle for the mul16_seq shift-and-add multiplier.
// Handshake: start is a one-cycle request honoured only while busy=0; done pulses once when out is valid.
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (output start, output a, output b, input busy, input done, input out);
  modport slave  (input start, input a, input b, output busy, output done, output out);
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 16 unsigned multiplier time-sharing one add16 over up to 16 steps.
// Optional macro MUL16_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.

module add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] sum
);
    // Carry out of bit 15 is intentionally dropped: the product is taken mod 2^16.
    assign sum = x + y;
endmodule

module mul16_seq (
    input  logic         clock,
    input  logic         reset,
    mul16_seq_if.slave   bus,
    output logic [0:0]   state_dbg
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;
    logic [15:0] sum;
    logic [15:0] acc_next;
    logic        last;
    logic        done_q;
    logic [15:0] out_q;

    add16 u_add (
        .x   (acc),
        .y   (mcand),
        .sum (sum)
    );

    always_comb begin
        acc_next = acc;
        if (mplier[0]) acc_next = sum;
    end

`ifdef MUL16_EARLY_EXIT_EN
    assign last = (cnt == 4'd15) || (mplier[15:1] == 15'd0);
`else
    assign last = (cnt == 4'd15);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= 16'd0;
            mcand  <= 16'd0;
            mplier <= 16'd0;
            cnt    <= 4'd0;
            done_q <= 1'b0;
            out_q  <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= 16'd0;
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        cnt    <= 4'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                    // The completing step publishes the sum including its own add.
                    if (last) begin
                        out_q  <= acc_next;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign state_dbg = state;
endmodule
